// File: rtl/vram_write_arbiter.sv
// ---------------------------------------------------------------------------
// vram_write_arbiter
//
// Shares the single-port image block memory between the VGA display read
// path and a pixel writer. The display always owns the port while it is
// busy. Writer requests are buffered in a small FIFO and committed one per
// cycle only while the display is idle (blanking). The display path goes
// straight through to the memory with no added latency.
//
// Ports:
//   clk         25 MHz pixel clock
//   rst         asynchronous, active-high reset
//   disp_busy   1 = display owns the memory port this cycle
//   disp_addr   display read address
//   wr_valid    writer request valid
//   wr_ready    FIFO can accept a request (combinational from level)
//   wr_addr     write address
//   wr_data     write pixel (4:4:4 RGB)
//   err_clr     clears range_err on the next edge
//   mem_addr    to block memory addra
//   mem_we      to block memory wea
//   mem_din     to block memory dina
//   fifo_level  number of buffered entries
//   range_err   sticky flag: an out-of-range write was dropped
//   wr_done     count of committed writes, wraps modulo 2^16
// ---------------------------------------------------------------------------
module vram_write_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int MEM_DEPTH  = 76800,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_busy,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              range_err,
  output logic [15:0]       wr_done
);

  // Pointers are one bit narrower than the level; FIFO_DEPTH is a power of
  // two, so they wrap modulo FIFO_DEPTH simply by overflowing.
  localparam int PTR_W = LVL_W - 1;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             range_err_q, range_err_d;
  logic [15:0]      wr_done_q, wr_done_d;

  logic push;
  logic push_store;
  logic push_drop;
  logic addr_in_range;
  logic commit;

  // Handshake and commit decisions. wr_ready looks only at the registered
  // level, so a full FIFO refuses a request even in a cycle that pops
  // (no bypass path from the pop into the ready signal).
  always_comb begin
    wr_ready      = !rst && (level_q < LVL_W'(FIFO_DEPTH));
    push          = wr_valid && wr_ready;
    addr_in_range = wr_addr < ADDR_W'(MEM_DEPTH);
    push_store    = push && addr_in_range;
    push_drop     = push && !addr_in_range;
    commit        = !disp_busy && (level_q != '0);
  end

  // Memory port mux. The display address passes straight through whenever
  // no write is being committed, so the read path sees zero extra latency.
  // Data is forced to zero when not writing to keep the bus quiet.
  always_comb begin
    mem_addr = disp_addr;
    mem_we   = 1'b0;
    mem_din  = '0;
    if (commit) begin
      mem_addr = fifo_addr_q[rd_ptr_q];
      mem_we   = 1'b1;
      mem_din  = fifo_data_q[rd_ptr_q];
    end
  end

  // Next-state for the FIFO storage, pointers and level. A push and a pop
  // in the same cycle leave the level unchanged; the pop always takes the
  // old head, and the new entry only becomes committable on the following
  // cycle because the head is read from registered storage.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;

    if (push_store) begin
      fifo_addr_d[wr_ptr_q] = wr_addr;
      fifo_data_d[wr_ptr_q] = wr_data;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end

    if (commit) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_store, commit})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Sticky range error and committed-write counter. A bad push on the same
  // edge as err_clr keeps the flag set so no error is ever lost.
  always_comb begin
    range_err_d = range_err_q;
    if (push_drop) begin
      range_err_d = 1'b1;
    end else if (err_clr) begin
      range_err_d = 1'b0;
    end

    wr_done_d = wr_done_q;
    if (commit) begin
      wr_done_d = wr_done_q + 16'd1;
    end
  end

  // State registers. Reset discards every pending entry immediately, which
  // also drops mem_we in the same cycle since commit depends on the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      range_err_q <= 1'b0;
      wr_done_q   <= '0;
    end else begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      range_err_q <= range_err_d;
      wr_done_q   <= wr_done_d;
    end
  end

  always_comb begin
    fifo_level = level_q;
    range_err  = range_err_q;
    wr_done    = wr_done_q;
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_write_arbiter
//
// Directed, self-checking bench for vram_write_arbiter. Inputs change 1 ns
// after the rising edge; outputs are sampled 1-2 ns after the edge.
// ---------------------------------------------------------------------------
module tb_vram_write_arbiter;

  logic        clk;
  logic        rst;
  logic        disp_busy;
  logic [16:0] disp_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        err_clr;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_din;
  logic [2:0]  fifo_level;
  logic        range_err;
  logic [15:0] wr_done;

  int checks = 0;
  int errors = 0;

  vram_write_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .disp_busy  (disp_busy),
    .disp_addr  (disp_addr),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .err_clr    (err_clr),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .fifo_level (fifo_level),
    .range_err  (range_err),
    .wr_done    (wr_done)
  );

  // 25 MHz pixel clock
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; disp_busy = 1'b1; disp_addr = 17'd5;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; err_clr = 1'b0;
    tick(); #1;
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", wr_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", mem_we); end
    checks++; if (mem_din !== 12'h000) begin errors++; $display("[TB] FAIL reset_din: got %h expected 000", mem_din); end
    checks++; if (wr_done !== 16'd0) begin errors++; $display("[TB] FAIL reset_done: got %0d expected 0", wr_done); end
    checks++; if (range_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", range_err); end
    checks++; if (mem_addr !== 17'd5) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 5", mem_addr); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", wr_ready); end
  endtask

  task automatic test_fill_busy();
    logic [11:0] fill_data [4];
    fill_data = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
    disp_busy = 1'b1; disp_addr = 17'd100;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 17'(i); wr_data = fill_data[i];
      #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_ready[%0d]: got %b expected 1", i, wr_ready); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fill_we[%0d]: got %b expected 0", i, mem_we); end
      tick();
      checks++; if (fifo_level !== 3'(i + 1)) begin errors++; $display("[TB] FAIL fill_level[%0d]: got %0d expected %0d", i, fifo_level, i + 1); end
    end
    wr_addr = 17'd10; wr_data = 12'hABC; disp_addr = 17'd200;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b expected 0", wr_ready); end
    tick(); tick();
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL stall_level: got %0d expected 4", fifo_level); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL stall_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 17'd200) begin errors++; $display("[TB] FAIL stall_addr: got %0d expected 200", mem_addr); end
    wr_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [11:0] fill_data [4];
    fill_data = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
    disp_busy = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL drain_we[%0d]: got %b expected 1", k, mem_we); end
      checks++; if (mem_addr !== 17'(k)) begin errors++; $display("[TB] FAIL drain_addr[%0d]: got %0d expected %0d", k, mem_addr, k); end
      checks++; if (mem_din !== fill_data[k]) begin errors++; $display("[TB] FAIL drain_din[%0d]: got %h expected %h", k, mem_din, fill_data[k]); end
      tick();
      checks++; if (fifo_level !== 3'(3 - k)) begin errors++; $display("[TB] FAIL drain_level[%0d]: got %0d expected %0d", k, fifo_level, 3 - k); end
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_ready[%0d]: got %b expected 1", k, wr_ready); end
    end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL empty_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 17'd200) begin errors++; $display("[TB] FAIL empty_addr: got %0d expected 200", mem_addr); end
    checks++; if (wr_done !== 16'd4) begin errors++; $display("[TB] FAIL drain_done: got %0d expected 4", wr_done); end
  endtask

  task automatic test_gated_drain();
    logic pat [6];
    int   next;
    pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    next = 0;
    disp_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 17'(1000 + i); wr_data = 12'(12'h100 + i);
      tick();
    end
    wr_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      disp_busy = pat[j]; disp_addr = 17'(50 + j);
      #1;
      if (pat[j]) begin
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL gate_we[%0d]: got %b expected 0", j, mem_we); end
        checks++; if (mem_addr !== 17'(50 + j)) begin errors++; $display("[TB] FAIL gate_addr[%0d]: got %0d expected %0d", j, mem_addr, 50 + j); end
      end else begin
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL gate_we[%0d]: got %b expected 1", j, mem_we); end
        checks++; if (mem_addr !== 17'(1000 + next)) begin errors++; $display("[TB] FAIL gate_addr[%0d]: got %0d expected %0d", j, mem_addr, 1000 + next); end
        checks++; if (mem_din !== 12'(12'h100 + next)) begin errors++; $display("[TB] FAIL gate_din[%0d]: got %h expected %h", j, mem_din, 12'h100 + next); end
        next++;
      end
      tick();
    end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL gate_level: got %0d expected 0", fifo_level); end
    checks++; if (wr_done !== 16'd7) begin errors++; $display("[TB] FAIL gate_done: got %0d expected 7", wr_done); end
  endtask

  task automatic test_range_error();
    disp_busy = 1'b1;
    wr_valid = 1'b1; wr_addr = 17'd76800; wr_data = 12'h123;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL bad_ready: got %b expected 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL bad_level: got %0d expected 0", fifo_level); end
    checks++; if (range_err !== 1'b1) begin errors++; $display("[TB] FAIL bad_err: got %b expected 1", range_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (range_err !== 1'b0) begin errors++; $display("[TB] FAIL clr_err: got %b expected 0", range_err); end
    wr_valid = 1'b1; err_clr = 1'b1;
    tick();
    wr_valid = 1'b0; err_clr = 1'b0;
    checks++; if (range_err !== 1'b1) begin errors++; $display("[TB] FAIL set_wins: got %b expected 1", range_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    wr_valid = 1'b1; wr_addr = 17'd76799; wr_data = 12'hFED;
    tick();
    wr_valid = 1'b0;
    checks++; if (range_err !== 1'b0) begin errors++; $display("[TB] FAIL edge_err: got %b expected 0", range_err); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("[TB] FAIL edge_level: got %0d expected 1", fifo_level); end
    disp_busy = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL edge_we: got %b expected 1", mem_we); end
    checks++; if (mem_addr !== 17'd76799) begin errors++; $display("[TB] FAIL edge_addr: got %0d expected 76799", mem_addr); end
    checks++; if (mem_din !== 12'hFED) begin errors++; $display("[TB] FAIL edge_din: got %h expected FED", mem_din); end
    tick();
    checks++; if (wr_done !== 16'd8) begin errors++; $display("[TB] FAIL edge_done: got %0d expected 8", wr_done); end
  endtask

  task automatic test_concurrent();
    disp_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_addr = 17'(2000 + i); wr_data = 12'(12'h200 + i);
      tick();
    end
    disp_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_addr = 17'(2002 + i); wr_data = 12'(12'h202 + i);
      #1;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL cc_we[%0d]: got %b expected 1", i, mem_we); end
      checks++; if (mem_addr !== 17'(2000 + i)) begin errors++; $display("[TB] FAIL cc_addr[%0d]: got %0d expected %0d", i, mem_addr, 2000 + i); end
      checks++; if (mem_din !== 12'(12'h200 + i)) begin errors++; $display("[TB] FAIL cc_din[%0d]: got %h expected %h", i, mem_din, 12'h200 + i); end
      tick();
      checks++; if (fifo_level !== 3'd2) begin errors++; $display("[TB] FAIL cc_level[%0d]: got %0d expected 2", i, fifo_level); end
      checks++; if (wr_done !== 16'(9 + i)) begin errors++; $display("[TB] FAIL cc_done[%0d]: got %0d expected %0d", i, wr_done, 9 + i); end
    end
    wr_valid = 1'b0;
    for (int i = 5; i < 7; i++) begin
      #1;
      checks++; if (mem_addr !== 17'(2000 + i)) begin errors++; $display("[TB] FAIL cc_tail_addr[%0d]: got %0d expected %0d", i, mem_addr, 2000 + i); end
      tick();
    end
    checks++; if (wr_done !== 16'd15) begin errors++; $display("[TB] FAIL cc_done_end: got %0d expected 15", wr_done); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL cc_level_end: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_reset_mid_drain();
    disp_busy = 1'b1;
    wr_valid = 1'b1; wr_addr = 17'd90000; wr_data = 12'h555;
    tick();
    for (int i = 0; i < 3; i++) begin
      wr_addr = 17'(3000 + i); wr_data = 12'(12'h300 + i);
      tick();
    end
    wr_valid = 1'b0;
    disp_busy = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_we: got %b expected 1", mem_we); end
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("[TB] FAIL pre_rst_level: got %0d expected 3", fifo_level); end
    checks++; if (range_err !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_err: got %b expected 1", range_err); end
    #5;
    rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_we: got %b expected 0", mem_we); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL rst_level: got %0d expected 0", fifo_level); end
    checks++; if (wr_done !== 16'd0) begin errors++; $display("[TB] FAIL rst_done: got %0d expected 0", wr_done); end
    checks++; if (range_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b expected 0", range_err); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b expected 0", wr_ready); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_ready: got %b expected 1", wr_ready); end
    tick();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_we: got %b expected 0", mem_we); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL post_rst_level: got %0d expected 0", fifo_level); end
  endtask

  initial begin
    test_reset();
    test_fill_busy();
    test_drain();
    test_gated_drain();
    test_range_error();
    test_concurrent();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
